// File: rtl/aui_rx_deskew.sv
// rtl/aui_rx_deskew.sv - 16-lane RX deskew and RS codeword rebuild; AUI_RX_STATS_EN adds error/lock counters
module aui_rx_deskew #(
  parameter int NUM_LANES     = 16,
  parameter int LANE_WIDTH    = 1360,
  parameter int WIDTH_WORD_RS = 4 * LANE_WIDTH,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            i_lane_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] i_lane_data,
  input  logic [NUM_LANES-1:0]            i_sync,
  output logic [WIDTH_WORD_RS-1:0]        word_A,
  output logic [WIDTH_WORD_RS-1:0]        word_B,
  output logic [WIDTH_WORD_RS-1:0]        word_C,
  output logic [WIDTH_WORD_RS-1:0]        word_D,
  output logic                            valid,
  output logic                            o_aligned,
  output logic                            o_deskew_err
`ifdef AUI_RX_STATS_EN
  ,
  output logic [15:0]                     o_err_count,
  output logic [15:0]                     o_lock_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {ST_HUNT, ST_ALIGNED, ST_ERROR} state_t;

  state_t                          state_q, state_d;
  logic [NUM_LANES-1:0]            lock_q, lock_d;
  logic                            valid_q, valid_d;
  logic [NUM_LANES*LANE_WIDTH-1:0] out_q;

  logic [PW-1:0]       wp_q [NUM_LANES];
  logic [PW-1:0]       rp_q [NUM_LANES];
  logic [LANE_WIDTH:0] mem_q [NUM_LANES][FIFO_DEPTH];

  logic [NUM_LANES-1:0]            empty, full, want, ovf, wr, pop_sync;
  logic [NUM_LANES*LANE_WIDTH-1:0] pop_data;
  logic                            pop, mixed, skew_err, err, flush;

  // Per-lane FIFO status and head-of-queue word ({sync, data})
  always_comb begin
    empty    = '0;
    full     = '0;
    pop_sync = '0;
    pop_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      empty[k]    = (wp_q[k] == rp_q[k]);
      full[k]     = (wp_q[k][AW] != rp_q[k][AW]) && (wp_q[k][AW-1:0] == rp_q[k][AW-1:0]);
      pop_sync[k] = mem_q[k][rp_q[k][AW-1:0]][LANE_WIDTH];
      pop_data[k*LANE_WIDTH +: LANE_WIDTH] = mem_q[k][rp_q[k][AW-1:0]][LANE_WIDTH-1:0];
    end
  end

  // Write qualification and error detection; a pop frees the slot so a full FIFO may still accept
  always_comb begin
    pop      = (state_q == ST_ALIGNED) && (empty == '0);
    want     = i_lane_valid & (lock_q | ({NUM_LANES{state_q == ST_HUNT}} & i_sync))
             & {NUM_LANES{state_q != ST_ERROR}};
    ovf      = want & full & {NUM_LANES{~pop}};
    wr       = want & ~ovf;
    mixed    = pop && (pop_sync != '0) && (pop_sync != '1);
    skew_err = (state_q == ST_HUNT) && ((lock_q & full) != '0) && (lock_q != '1);
    err      = (ovf != '0) || skew_err || mixed;
  end

  // Next-state logic for HUNT / ALIGNED / ERROR
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    valid_d = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        lock_d = lock_q | (i_lane_valid & i_sync);
        if (err) begin
          state_d = ST_ERROR;
        end else if ((lock_q == '1) && (empty == '0)) begin
          state_d = ST_ALIGNED;
        end
      end
      ST_ALIGNED: begin
        valid_d = pop && !err;
        if (err) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        lock_d  = '0;
        flush   = 1'b1;
        state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Control state, lock bits, output register and FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HUNT;
      lock_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        wp_q[k] <= '0;
        rp_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      if (pop) begin
        out_q <= pop_data;
      end
      for (int k = 0; k < NUM_LANES; k++) begin
        if (flush) begin
          wp_q[k] <= '0;
          rp_q[k] <= '0;
        end else begin
          if (wr[k]) wp_q[k] <= wp_q[k] + PW'(1);
          if (pop)   rp_q[k] <= rp_q[k] + PW'(1);
        end
      end
    end
  end

  // FIFO storage carries no reset; emptiness is tracked solely by the pointers
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (wr[k]) begin
        mem_q[k][wp_q[k][AW-1:0]] <= {i_sync[k], i_lane_data[k*LANE_WIDTH +: LANE_WIDTH]};
      end
    end
  end

  assign word_A       = out_q[0*WIDTH_WORD_RS +: WIDTH_WORD_RS];
  assign word_B       = out_q[1*WIDTH_WORD_RS +: WIDTH_WORD_RS];
  assign word_C       = out_q[2*WIDTH_WORD_RS +: WIDTH_WORD_RS];
  assign word_D       = out_q[3*WIDTH_WORD_RS +: WIDTH_WORD_RS];
  assign valid        = valid_q;
  assign o_aligned    = (state_q == ST_ALIGNED);
  assign o_deskew_err = (state_q == ST_ERROR);

`ifdef AUI_RX_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d, lock_cnt_q, lock_cnt_d;

  // Saturating counts of ERROR entries and HUNT->ALIGNED transitions
  always_comb begin
    err_cnt_d  = err_cnt_q;
    lock_cnt_d = lock_cnt_q;
    if ((state_d == ST_ERROR) && (state_q != ST_ERROR) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if ((state_q == ST_HUNT) && (state_d == ST_ALIGNED) && (lock_cnt_q != 16'hFFFF)) begin
      lock_cnt_d = lock_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign o_err_count  = err_cnt_q;
  assign o_lock_count = lock_cnt_q;
`endif

endmodule

// File: tb/tb_aui_rx_deskew.sv
// tb/tb_aui_rx_deskew.sv - scoreboard bench for aui_rx_deskew
module tb_aui_rx_deskew;

  localparam int NL = 16;
  localparam int LW = 1360;
  localparam int WW = 4 * LW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NL-1:0]      i_lane_valid = '0;
  logic [NL*LW-1:0]   i_lane_data = '0;
  logic [NL-1:0]      i_sync = '0;
  logic [WW-1:0]      word_A, word_B, word_C, word_D;
  logic               valid, o_aligned, o_deskew_err;
`ifdef AUI_RX_STATS_EN
  logic [15:0]        err_count, lock_count;
`endif

  aui_rx_deskew dut (
    .clk          (clk),
    .rst          (rst),
    .i_lane_valid (i_lane_valid),
    .i_lane_data  (i_lane_data),
    .i_sync       (i_sync),
    .word_A       (word_A),
    .word_B       (word_B),
    .word_C       (word_C),
    .word_D       (word_D),
    .valid        (valid),
    .o_aligned    (o_aligned),
    .o_deskew_err (o_deskew_err)
`ifdef AUI_RX_STATS_EN
    ,
    .o_err_count  (err_count),
    .o_lock_count (lock_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          err_seen = 0;
  int          n_valid = 0;
  int          first_valid_cyc = -1;
  int          start_cyc = 0;
  logic [15:0] sb [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] tag, input int j, input int k);
    return {tag, 8'(j), 16'(k)};
  endfunction

  function automatic logic [LW-1:0] lane_out(input int k);
    logic [WW-1:0] w;
    case (k / 4)
      0:       w = word_A;
      1:       w = word_B;
      2:       w = word_C;
      default: w = word_D;
    endcase
    return w[(k % 4) * LW +: LW];
  endfunction

  function automatic logic [63:0] fold(input logic [LW-1:0] v);
    return {v[LW-1 -: 32], v[31:0]};
  endfunction

  // Monitor: error-cycle outputs and scoreboard comparison of every valid beat
  always @(negedge clk) begin
    logic [15:0] e;
    if (o_deskew_err) begin
      err_seen++;
      check("err_valid", 64'(valid), 64'd0);
      check("err_aligned", 64'(o_aligned), 64'd0);
    end
    if (valid) begin
      n_valid++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < NL; k++) begin
          check($sformatf("lane%0d", k), fold(lane_out(k)), {pat(e[15:8], int'(e[7:0]), k), pat(e[15:8], int'(e[7:0]), k)});
        end
      end
    end
  end

  // All lanes send nbeats words; skew_lane lags by skew cycles. Beat sync_beat carries sync on every
  // lane; lone_lane also raises sync on lone_beat. Beats below push_n are expected at the output.
  task automatic send_stream(input int skew_lane, input int skew, input int nbeats, input logic [7:0] tag,
                             input int sync_beat, input int lone_lane, input int lone_beat, input int push_n);
    logic [LW-1:0] v;
    int j;
    int jl;
    for (int c = 0; c < nbeats + skew; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      i_lane_valid = '0;
      i_sync       = '0;
      i_lane_data  = '0;
      for (int k = 0; k < NL; k++) begin
        j = (k == skew_lane) ? c - skew : c;
        if (j >= 0 && j < nbeats) begin
          v = '0;
          v[31:0]      = pat(tag, j, k);
          v[LW-1 -: 32] = pat(tag, j, k);
          i_lane_valid[k] = 1'b1;
          i_sync[k]       = (j == sync_beat) || (k == lone_lane && j == lone_beat);
          i_lane_data[k*LW +: LW] = v;
        end
      end
      jl = c - skew;
      if (jl >= 0 && jl < push_n) sb.push_back({tag, 8'(jl)});
    end
    @(posedge clk); #1;
    i_lane_valid = '0;
    i_sync       = '0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [LW-1:0] v;
    // Reset state
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_aligned", 64'(o_aligned), 64'd0);
    check("rst_err", 64'(o_deskew_err), 64'd0);
    check("rst_wordA", fold(lane_out(0)), 64'd0);
    check("rst_wordD", fold(lane_out(15)), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero skew: sync plus 3 words, valid two cycles after the sync write
    n_valid = 0;
    first_valid_cyc = -1;
    send_stream(0, 0, 4, 8'h01, 0, -1, -1, 4);
    drain();
    check("s1_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("s1_nvalid", 64'(n_valid), 64'd4);
    check("s1_aligned", 64'(o_aligned), 64'd1);
    check("s1_no_err", 64'(err_seen), 64'd0);

    // Lane 15 delayed by 5 words
    do_reset();
    n_valid = 0;
    send_stream(15, 5, 4, 8'h01, 0, -1, -1, 4);
    drain();
    check("s2_nvalid", 64'(n_valid), 64'd4);
    check("s2_aligned", 64'(o_aligned), 64'd1);
    check("s2_no_err", 64'(err_seen), 64'd0);

    // Lane 7 delayed by 8 words: beyond the FIFO, must error and return to HUNT
    do_reset();
    send_stream(7, 8, 10, 8'h03, 0, -1, -1, 0);
    drain();
    check("s3_err", 64'(err_seen), 64'd1);
    check("s3_hunt", 64'(o_aligned), 64'd0);
    n_valid = 0;
    send_stream(0, 0, 3, 8'h13, 0, -1, -1, 3);
    drain();
    check("s3_realign_nvalid", 64'(n_valid), 64'd3);
    check("s3_realigned", 64'(o_aligned), 64'd1);

    // Sync on lane 4 only while aligned
    send_stream(0, 0, 3, 8'h04, -1, 4, 1, 1);
    drain();
    check("s4_err", 64'(err_seen), 64'd2);
    check("s4_hunt", 64'(o_aligned), 64'd0);
`ifdef AUI_RX_STATS_EN
    check("stat_err_count", 64'(err_count), 64'd2);
    check("stat_lock_count", 64'(lock_count), 64'd1);
`endif

    // Reset mid-stream with FIFOs partly filled
    send_stream(0, 0, 4, 8'h05, 0, -1, -1, 4);
    drain();
    check("s5_aligned", 64'(o_aligned), 64'd1);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      i_lane_valid = 16'h7FFF;
      i_sync       = '0;
      for (int k = 0; k < NL; k++) begin
        v = '0;
        v[31:0] = pat(8'h55, j, k);
        i_lane_data[k*LW +: LW] = v;
      end
    end
    @(posedge clk); #1;
    i_lane_valid = '0;
    #2;
    rst = 1'b0;
    #1;
    check("s5_valid", 64'(valid), 64'd0);
    check("s5_aligned_rst", 64'(o_aligned), 64'd0);
    check("s5_err", 64'(o_deskew_err), 64'd0);
    check("s5_wordA", fold(lane_out(0)), 64'd0);
    check("s5_wordD", fold(lane_out(15)), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_stream(0, 0, 3, 8'h06, -1, -1, -1, 0);
    drain();
    check("s5_no_lock", 64'(o_aligned), 64'd0);
    n_valid = 0;
    send_stream(0, 0, 4, 8'h16, 0, -1, -1, 4);
    drain();
    check("s5_relock_nvalid", 64'(n_valid), 64'd4);
    check("s5_relocked", 64'(o_aligned), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
